draw_cmd_encoder: RTL

Command transmitter for the drawing FIFO. It takes one drawing request at a time from game or menu logic and packs it into the 32-bit draw-command word format consumed by the FIFO-side command decoder. It writes the one or two resulting words into the command FIFO and honours the FIFO's full flag. It sits between request sources (snake logic, score/text overlay) and the FIFO write port (wren/wdat).

---
 rtl/draw_cmd_encoder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/draw_cmd_encoder.sv
// draw_cmd_encoder
// Packs one drawing request at a time into one or two 32-bit draw-command
// words and writes them into the command FIFO. The FIFO full flag is honoured.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   req_vld / req_rdy      request handshake (accepted when both high)
//   req_type               0=superpixel, 1=superpixel rect, 2=pixel rect, 3=char
//   req_x0..req_size       request fields (coordinates, colours, char data)
//   ff_full                command FIFO full
//   cmd / cmd_vld          FIFO write data / write enable
//   busy                   a command is being emitted
//   err                    one-cycle pulse when a request fails its range check
//   words_sent             wrapping count of words written to the FIFO
module draw_cmd_encoder #(
  parameter logic [4:0] H_LOGIC_MAX = 5'd31,
  parameter logic [4:0] V_LOGIC_MAX = 5'd23,
  parameter logic [9:0] H_PHY_MAX   = 10'd639,
  parameter logic [8:0] V_PHY_MAX   = 9'd479,
  parameter int         CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [1:0]           req_type,
  input  logic [9:0]           req_x0,
  input  logic [8:0]           req_y0,
  input  logic [9:0]           req_x1,
  input  logic [8:0]           req_y1,
  input  logic [7:0]           req_color,
  input  logic [7:0]           req_bg,
  input  logic [7:0]           req_code,
  input  logic [3:0]           req_size,
  input  logic                 ff_full,
  output logic [31:0]          cmd,
  output logic                 cmd_vld,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] words_sent
);

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B} state_t;

  state_t                 state;
  logic [31:0]            word_a_reg;
  logic [31:0]            word_b_reg;
  logic                   two_word_reg;
  logic                   err_reg;
  logic [CNT_WIDTH-1:0]   cnt_reg;

  logic                   accept;
  logic                   chk_ok;
  logic                   two_word;
  logic [31:0]            word_a;
  logic [31:0]            word_b;

  // Logic-coordinate limits widened to the request field widths.
  logic [9:0] h_logic_w;
  logic [8:0] v_logic_w;
  assign h_logic_w = {5'd0, H_LOGIC_MAX};
  assign v_logic_w = {4'd0, V_LOGIC_MAX};

  assign req_rdy = (state == IDLE) & ~rst;
  assign accept  = req_vld & req_rdy;
  assign cmd_vld = (state != IDLE) & ~ff_full & ~rst;
  assign busy    = (state != IDLE);
  assign err     = err_reg;
  assign words_sent = cnt_reg;

  // Range check and word build straight from the request inputs; the results
  // are captured into the holding registers at the accepting edge.
  always_comb begin
    chk_ok   = 1'b1;
    two_word = 1'b0;
    word_a   = '0;
    word_b   = '0;
    case (req_type)
      2'd0: begin
        chk_ok = (req_x0 <= h_logic_w) && (req_y0 <= v_logic_w);
        word_a = {4'h0, req_x0[4:0], req_y0[4:0], req_color, 10'd0};
      end
      2'd1: begin
        chk_ok = (req_x0 <= h_logic_w) && (req_x1 <= h_logic_w) &&
                 (req_y0 <= v_logic_w) && (req_y1 <= v_logic_w) &&
                 (req_x0 <= req_x1) && (req_y0 <= req_y1);
        word_a = {4'h1, req_x0[4:0], req_y0[4:0], req_x1[4:0], req_y1[4:0], req_color};
      end
      2'd2: begin
        chk_ok   = (req_x0 <= H_PHY_MAX) && (req_x1 <= H_PHY_MAX) &&
                   (req_y0 <= V_PHY_MAX) && (req_y1 <= V_PHY_MAX) &&
                   (req_x0 <= req_x1) && (req_y0 <= req_y1);
        two_word = 1'b1;
        word_a   = {4'h9, req_x0, req_y0, req_color, 1'b0};
        word_b   = {4'h9, req_x1, req_y1, req_color, 1'b1};
      end
      default: begin
        chk_ok   = (req_x0 <= H_PHY_MAX) && (req_y0 <= V_PHY_MAX) && (req_size != 4'd0);
        two_word = 1'b1;
        word_a   = {4'hA, req_x0, req_y0, req_code, 1'b0};
        word_b   = {4'hA, req_color, req_bg, req_size, 7'd0, 1'b1};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word_a_reg   <= '0;
      word_b_reg   <= '0;
      two_word_reg <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      err_reg <= 1'b0;
      if (cmd_vld)
        cnt_reg <= cnt_reg + 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            if (chk_ok) begin
              word_a_reg   <= word_a;
              word_b_reg   <= word_b;
              two_word_reg <= two_word;
              state        <= SEND_A;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        SEND_A: begin
          if (cmd_vld)
            state <= two_word_reg ? SEND_B : IDLE;
        end
        SEND_B: begin
          if (cmd_vld)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word on the FIFO bus follows the state; it is held steady through stalls.
  always_comb begin
    case (state)
      SEND_A:  cmd = word_a_reg;
      SEND_B:  cmd = word_b_reg;
      default: cmd = '0;
    endcase
  end

endmodule
